// File: rtl/cache_2way_wb_sync.sv
// Two-way set-associative write-back / write-allocate cache with per-set LRU,
// byte-enabled CPU writes and a req/ack block-wide memory port.
module cache_2way_wb_sync #(
    parameter int ADDR_W          = 10,
    parameter int NUM_SETS        = 2,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cpu_req,
    input  logic                            cpu_we,
    input  logic [ADDR_W-1:0]               cpu_addr,
    input  logic [31:0]                     cpu_wdata,
    input  logic [3:0]                      cpu_be,
    output logic [31:0]                     cpu_rdata,
    output logic                            cpu_ready,
    output logic                            hit,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [32*WORDS_PER_BLOCK-1:0]   mem_wdata,
    input  logic [32*WORDS_PER_BLOCK-1:0]   mem_rdata,
    input  logic                            mem_ack
);
    localparam int OFF_W  = 2 + $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W  = 32 * WORDS_PER_BLOCK;
    localparam int WSEL_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] WB     = 3'd2;
    localparam logic [2:0] FILL   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [BLK_W-1:0]    data_arr [2][NUM_SETS];
    logic [TAG_W-1:0]    tag_arr  [2][NUM_SETS];
    logic [NUM_SETS-1:0] valid_arr [2];
    logic [NUM_SETS-1:0] dirty_arr [2];
    logic [NUM_SETS-1:0] lru;

    logic [2:0]        state;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              victim;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_word;
    logic [WSEL_W+4:0] word_lsb;
    logic [1:0]        way_hit;
    logic              hit_way;
    logic              victim_c;
    logic              acc_way;
    logic [31:0]       cur_word;
    logic [31:0]       merged;

    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_word = WSEL_W'((req_addr >> 2) & ADDR_W'(WORDS_PER_BLOCK - 1));
    assign word_lsb = {req_word, 5'd0};

    assign way_hit[0] = valid_arr[0][req_idx] && (tag_arr[0][req_idx] == req_tag);
    assign way_hit[1] = valid_arr[1][req_idx] && (tag_arr[1][req_idx] == req_tag);
    assign hit_way    = !way_hit[0];
    assign victim_c   = !valid_arr[0][req_idx] ? 1'b0 :
                        !valid_arr[1][req_idx] ? 1'b1 : lru[req_idx];

    // RESP replays the access on the freshly filled victim; LOOKUP uses the hitting way.
    assign acc_way  = (state == RESP) ? victim : hit_way;
    assign cur_word = data_arr[acc_way][req_idx][word_lsb +: 32];

    always_comb begin
        merged = cur_word;
        for (int k = 0; k < 4; k++) begin
            if (req_be[k]) merged[8*k +: 8] = req_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            valid_arr[0] <= '0;
            valid_arr[1] <= '0;
            dirty_arr[0] <= '0;
            dirty_arr[1] <= '0;
            lru          <= '0;
            cpu_ready    <= 1'b0;
            hit          <= 1'b0;
            cpu_rdata    <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            victim       <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            hit       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        req_be    <= cpu_be;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (way_hit != 2'b00) begin
                        if (req_we) begin
                            data_arr[acc_way][req_idx][word_lsb +: 32] <= merged;
                            dirty_arr[acc_way][req_idx] <= 1'b1;
                        end else begin
                            cpu_rdata <= cur_word;
                        end
                        lru[req_idx] <= ~hit_way;
                        cpu_ready    <= 1'b1;
                        hit          <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        victim  <= victim_c;
                        mem_req <= 1'b1;
                        if (valid_arr[victim_c][req_idx] && dirty_arr[victim_c][req_idx]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_arr[victim_c][req_idx], req_idx, {OFF_W{1'b0}}};
                            mem_wdata <= data_arr[victim_c][req_idx];
                            state     <= WB;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            state    <= FILL;
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        dirty_arr[victim][req_idx] <= 1'b0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    // After a write-back the request is dropped for a cycle before the fill starts.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                    end else if (mem_ack) begin
                        data_arr[victim][req_idx]  <= mem_rdata;
                        tag_arr[victim][req_idx]   <= req_tag;
                        valid_arr[victim][req_idx] <= 1'b1;
                        dirty_arr[victim][req_idx] <= 1'b0;
                        lru[req_idx] <= ~victim;
                        mem_req      <= 1'b0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (req_we) begin
                        data_arr[acc_way][req_idx][word_lsb +: 32] <= merged;
                        dirty_arr[acc_way][req_idx] <= 1'b1;
                    end else begin
                        cpu_rdata <= cur_word;
                    end
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_2way_wb_sync.sv
// Directed bench for cache_2way_wb_sync: hand-computed lines, hits, evictions,
// delayed acks and a mid-fill reset, checked with immediate assertions.
module tb_cache_2way_wb_sync;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_be;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         hit;
    logic         mem_req;
    logic         mem_we;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;

    int checks = 0;
    int fails  = 0;

    localparam logic [127:0] L1  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] L1M = {32'h44444444, 32'h33333333, 32'h222222AB, 32'h11111111};
    localparam logic [127:0] L2  = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
    localparam logic [127:0] L3  = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    localparam logic [127:0] L4  = {32'hF3F3F3F3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
    localparam logic [127:0] L5  = {32'h5D5D5D5D, 32'h5C5C5C5C, 32'h5B5B5B5B, 32'h5A5A5A5A};
    localparam logic [127:0] L6  = {32'h6D6D6D6D, 32'h6C6C6C6C, 32'h6B6B6B6B, 32'h6A6A6A6A};
    localparam logic [127:0] JUNK = {4{32'hBADBAD00}};

    cache_2way_wb_sync #(.ADDR_W(10), .NUM_SETS(2), .WORDS_PER_BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit(hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    // Called right after issue(): the request is in LOOKUP, ready is due next cycle.
    task automatic expect_hit(input string tag, input logic [31:0] rd);
        @(negedge clk);
        chk({tag, "_ready"}, cpu_ready, 1'b1);
        chk({tag, "_hit"}, hit, 1'b1);
        chk({tag, "_rdata"}, cpu_rdata, rd);
        chk({tag, "_no_mem"}, mem_req, 1'b0);
        @(negedge clk);
        chk({tag, "_ready_pulse"}, cpu_ready, 1'b0);
    endtask

    task automatic mem_serve(input string tag, input logic exp_we, input logic [9:0] exp_addr,
                             input logic [127:0] exp_wdata, input int delay,
                             input logic [127:0] rdata, input logic poke);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_rise"}, mem_req, 1'b1);
        if (mem_req) begin
            for (int i = 0; i < delay; i++) begin
                chk({tag, "_req_hold"}, mem_req, 1'b1);
                chk({tag, "_we"}, mem_we, exp_we);
                chk({tag, "_addr"}, mem_addr, exp_addr);
                if (exp_we) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
                if (poke && i == 1) begin
                    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
                end
                if (poke && i == 2) cpu_req = 1'b0;
                if (i == delay - 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
                @(negedge clk);
            end
            mem_ack = 1'b0;
            mem_rdata = JUNK;
            chk({tag, "_req_drop"}, mem_req, 1'b0);
        end
    endtask

    task automatic expect_miss_done(input string tag, input logic [31:0] rd);
        int n = 0;
        while (!cpu_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, cpu_ready, 1'b1);
        chk({tag, "_hit"}, hit, 1'b0);
        chk({tag, "_rdata"}, cpu_rdata, rd);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [31:0] rd_seen;
        logic hit_seen;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_be = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cpu_ready, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 10'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold read fills way0 of set 1
        issue(1'b0, 10'h010, 32'h0, 4'h0);
        mem_serve("s1_fill", 1'b0, 10'h010, '0, 1, L1, 1'b0);
        expect_miss_done("s1", 32'h11111111);

        issue(1'b0, 10'h014, 32'h0, 4'h0);
        expect_hit("s2", 32'h22222222);

        // Byte write: rdata must keep the last read value
        issue(1'b1, 10'h014, 32'hDEADBEAB, 4'b0001);
        expect_hit("s3_wr", 32'h22222222);
        issue(1'b0, 10'h014, 32'h0, 4'h0);
        expect_hit("s3_rd", 32'h222222AB);

        // Fill way1, then evict dirty way0
        issue(1'b0, 10'h030, 32'h0, 4'h0);
        mem_serve("s4a_fill", 1'b0, 10'h030, '0, 1, L2, 1'b0);
        expect_miss_done("s4a", 32'h55555555);
        issue(1'b0, 10'h050, 32'h0, 4'h0);
        mem_serve("s4b_wb", 1'b1, 10'h010, L1M, 1, JUNK, 1'b0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_serve("s4b_fill", 1'b0, 10'h050, '0, 1, L3, 1'b0);
        expect_miss_done("s4b", 32'hAAAAAAAA);

        // Slow memory with a stray cpu_req while busy
        issue(1'b0, 10'h078, 32'h0, 4'h0);
        mem_serve("s5_fill", 1'b0, 10'h070, '0, 5, L4, 1'b1);
        cnt = 0; rd_seen = '0; hit_seen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (cpu_ready) begin
                cnt++;
                rd_seen = cpu_rdata;
                hit_seen = hit;
            end
            @(negedge clk);
        end
        chk("s5_ready_count", cnt, 1);
        chk("s5_rdata", rd_seen, 32'hE2E2E2E2);
        chk("s5_hit", hit_seen, 1'b0);
        chk("s5_no_mem", mem_req, 1'b0);

        // Reset while a fill is outstanding
        issue(1'b0, 10'h000, 32'h0, 4'h0);
        cnt = 0;
        while (!mem_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("s6_req_rise", mem_req, 1'b1);
        chk("s6_addr", mem_addr, 10'h000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("s6_rst_mem_req", mem_req, 1'b0);
        chk("s6_rst_ready", cpu_ready, 1'b0);
        chk("s6_rst_mem_addr", mem_addr, 10'h0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 10'h000, 32'h0, 4'h0);
        mem_serve("s6_refill", 1'b0, 10'h000, '0, 2, L5, 1'b0);
        expect_miss_done("s6", 32'h5A5A5A5A);
        issue(1'b0, 10'h050, 32'h0, 4'h0);
        mem_serve("s6_inval", 1'b0, 10'h050, '0, 1, L3, 1'b0);
        expect_miss_done("s6b", 32'hAAAAAAAA);

        // Empty byte-enable write: data intact but line becomes dirty
        issue(1'b1, 10'h000, 32'hFFFFFFFF, 4'b0000);
        expect_hit("s7_wr", 32'hAAAAAAAA);
        issue(1'b0, 10'h000, 32'h0, 4'h0);
        expect_hit("s7_rd", 32'h5A5A5A5A);
        issue(1'b0, 10'h024, 32'h0, 4'h0);
        mem_serve("s7_fill_w1", 1'b0, 10'h020, '0, 1, L6, 1'b0);
        expect_miss_done("s7a", 32'h6B6B6B6B);
        issue(1'b0, 10'h040, 32'h0, 4'h0);
        mem_serve("s7_wb", 1'b1, 10'h000, L5, 3, JUNK, 1'b0);
        mem_serve("s7_fill", 1'b0, 10'h040, '0, 1, L2, 1'b0);
        expect_miss_done("s7b", 32'h55555555);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/cache_2way_wb_sync.md
Name: cache_2way_wb_sync

Overview:
- Synchronous, parametrised 2-way set-associative write-back, write-allocate cache with LRU replacement.
- Sits between the CPU load/store path and the block-wide main-memory model.
- Uses a req/ready handshake on the CPU side and a req/ack handshake on the memory side.
- Adds per-byte write enables and multi-cycle memory latency support.

Parameters:
- ADDR_W, 10, byte-address width.
- NUM_SETS, 2, number of sets; power of 2, ≥2.
- WORDS_PER_BLOCK, 4, 32-bit words per line; power of 2, ≥1.
- Derived: OFF_W = 2+log2(WORDS_PER_BLOCK); IDX_W = log2(NUM_SETS); TAG_W = ADDR_W-IDX_W-OFF_W; BLK_W = 32*WORDS_PER_BLOCK.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- cpu_req  input  1  request valid; sampled only in IDLE
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata  input  32  write data
- cpu_be  input  4  byte enables for writes; bit k covers byte k
- cpu_rdata  output  32  read data; valid while cpu_ready=1
- cpu_ready  output  1  one-cycle completion pulse
- hit  output  1  lookup result; valid while cpu_ready=1
- mem_req  output  1  memory transaction request
- mem_we  output  1  1 = write-back, 0 = fill
- mem_addr  output  ADDR_W  line-aligned address (offset bits 0)
- mem_wdata  output  BLK_W  victim line; word0 in [31:0]
- mem_rdata  input  BLK_W  fill line; word0 in [31:0]
- mem_ack  input  1  one-cycle completion; mem_rdata valid in the same cycle for fills

Behaviour:
- Address split: tag = [ADDR_W-1:IDX_W+OFF_W]; index = [IDX_W+OFF_W-1:OFF_W]; word = [OFF_W-1:2].
- Storage per set: 2 ways, each holding valid, dirty, tag and data; one lru bit per set naming the least-recently-used way.
- Reset (rst_n=0 at a clock edge):
  - All valid, dirty and lru bits cleared; data and tag arrays not reset.
  - cpu_ready=0, hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; state=IDLE.
  - Reset mid-transaction abandons it; mem_req drops on the next edge; no line is marked valid.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP.
  - IDLE: when cpu_req=1, latch we/addr/wdata/be and go to LOOKUP. cpu_req is ignored in every other state.
  - LOOKUP: compare both ways of the set; a way matches if valid=1 and its tag equals the latched tag.
    - Hit: reads drive cpu_rdata with the word; writes merge bytes where be=1 and set dirty. Assert cpu_ready=1, hit=1; lru := other way; go to IDLE. Hit latency is one cycle after acceptance.
    - Miss: victim = way0 if invalid, else way1 if invalid, else the lru way. Go to WB if the victim is valid and dirty, otherwise go to FILL.
  - WB: mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line. Hold all until mem_ack, then clear victim dirty and go to FILL.
  - FILL: mem_req=1, mem_we=0, mem_addr = {req tag, index, 0}. On mem_ack write mem_rdata into the victim, set valid=1, tag=req tag, dirty=0, lru := other way, and go to RESP.
  - RESP: perform the access on the filled line as on a hit, except hit=0. Writes set dirty. cpu_ready=1 for one cycle; go to IDLE.
- Memory handshake:
  - mem_req deasserts in the cycle after mem_ack.
  - mem_ack while mem_req=0 is ignored.
  - mem_ack may arrive any number of cycles (≥1) after mem_req rises.
- Outputs:
  - cpu_ready and hit are 0 outside completion cycles.
  - cpu_rdata holds its last value until the next read completion.
  - A write leaves cpu_rdata unchanged.
- Write with be=4'b0000 completes normally and leaves data unchanged, but still sets dirty and updates lru.
- A new cpu_req may be accepted in the cycle after cpu_ready.

Test Plan (defaults):
1. Cold read 0x010; memory acks 1 cycle after mem_req with line {D3,D2,D1,0x11111111} → mem_req=1, mem_we=0, mem_addr=0x010. Then RESP: cpu_ready=1, hit=0, cpu_rdata=0x11111111.
2. Read 0x014 after scenario 1 → cpu_ready one cycle after acceptance, hit=1, no mem_req.
3. Write 0x014, wdata=0xDEADBEAB, be=4'b0001 → hit=1. A following read of 0x014 returns D1 with byte0 replaced by 0xAB.
4. Read 0x030 (fills way1), then read 0x050:
   - Evicts dirty way0: WB first with mem_we=1, mem_addr=0x010, mem_wdata[63:32] = modified D1.
   - Then FILL with mem_addr=0x050; hit=0.
5. mem_ack delayed 5 cycles → mem_req, mem_addr and mem_wdata stay stable for 5 cycles. An extra cpu_req in that window is ignored; exactly one cpu_ready is produced.
6. rst_n=0 during FILL → next edge: mem_req=0, cpu_ready=0. A subsequent read of the same address misses (hit=0).
